// File: rtl/uart_tx_arbiter_if.sv
// Requester and uart-side signals of the packet arbiter, bundled as one bus.
// The arbiter connects through the master modport; clients/uart model use slave.
interface uart_tx_arbiter_if #(
  parameter int N = 4
);
  // Handshake: a byte moves on a cycle where its valid (uart_tx_rdy on the uart
  // side) is high and the acceptor's one-cycle ack is high. The source holds
  // data/last stable while valid is high and unacked; ack only occurs with rdy.
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ack;
  logic [7:0]     uart_tx_data;
  logic           uart_tx_rdy;
  logic           uart_tx_ack;

  modport master (
    input  req_data, req_valid, req_last, uart_tx_ack,
    output req_ack, uart_tx_data, uart_tx_rdy
  );

  modport slave (
    output req_data, req_valid, req_last, uart_tx_ack,
    input  req_ack, uart_tx_data, uart_tx_rdy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-contiguous arbiter sharing one uart transmitter among N
// byte-stream requesters, with optional channel header, idle timeout and length cap.
module uart_tx_arbiter #(
  parameter int         N         = 4,
  parameter int         HDR_EN    = 1,
  parameter logic [7:0] HDR_BASE  = 8'hA0,
  parameter int         TIMEOUT   = 1000,
  parameter int         MAX_BYTES = 256
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_arbiter_if.master  bus,
  output logic [3:0]         grant_id,
  output logic               busy,
  output logic               abort_pulse,
  output logic               trunc_pulse,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  last_ptr;
  logic [15:0] byte_cnt;
  logic [31:0] idle_cnt;

  logic [7:0]  sel_data;
  logic        sel_valid;
  logic        sel_last;
  logic [3:0]  pick;
  int          best_d;
  int          d;
  logic        pay_acc;
  logic        cap_hit;
  logic        timeout_hit;

  assign state_dbg = state;

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (grant_id == 4'(i)) begin
        sel_data  = bus.req_data[8*i +: 8];
        sel_valid = bus.req_valid[i];
        sel_last  = bus.req_last[i];
      end
    end
  end

  // Priority distance from last_ptr+1; last_ptr itself is the furthest (N-1).
  always_comb begin
    pick   = last_ptr;
    best_d = N;
    d      = 0;
    for (int i = 0; i < N; i++) begin
      d = (i + N - 1 - int'(last_ptr)) % N;
      if (bus.req_valid[i] && (d < best_d)) begin
        best_d = d;
        pick   = 4'(i);
      end
    end
  end

  assign pay_acc     = (state == PAYLOAD) && sel_valid && bus.uart_tx_ack;
  assign cap_hit     = (MAX_BYTES != 0) && ((byte_cnt + 16'd1) == 16'(MAX_BYTES));
  assign timeout_hit = (TIMEOUT != 0) && (idle_cnt == 32'(TIMEOUT - 1));

  always_comb begin
    bus.uart_tx_rdy  = 1'b0;
    bus.uart_tx_data = '0;
    bus.req_ack      = '0;
    case (state)
      HEADER: begin
        bus.uart_tx_rdy  = 1'b1;
        bus.uart_tx_data = HDR_BASE + {4'd0, grant_id};
      end
      PAYLOAD: begin
        bus.uart_tx_rdy  = sel_valid;
        bus.uart_tx_data = sel_data;
        for (int i = 0; i < N; i++) begin
          if (grant_id == 4'(i)) bus.req_ack[i] = bus.uart_tx_ack & sel_valid;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      grant_id    <= 4'd0;
      last_ptr    <= 4'(N - 1);
      byte_cnt    <= '0;
      idle_cnt    <= '0;
      abort_pulse <= 1'b0;
      trunc_pulse <= 1'b0;
    end else begin
      abort_pulse <= 1'b0;
      trunc_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.req_valid) begin
            grant_id <= pick;
            last_ptr <= pick;
            busy     <= 1'b1;
            byte_cnt <= '0;
            idle_cnt <= '0;
            state    <= (HDR_EN != 0) ? HEADER : PAYLOAD;
          end
        end
        HEADER: begin
          if (bus.uart_tx_ack) state <= PAYLOAD;
        end
        PAYLOAD: begin
          if (pay_acc) begin
            idle_cnt <= '0;
            byte_cnt <= byte_cnt + 16'd1;
            // A last byte that also hits the cap is a normal end, not a truncation.
            if (sel_last) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else if (cap_hit) begin
              state       <= IDLE;
              busy        <= 1'b0;
              trunc_pulse <= 1'b1;
            end
          end else if (!sel_valid) begin
            if (timeout_hit) begin
              state       <= IDLE;
              busy        <= 1'b0;
              abort_pulse <= 1'b1;
            end else begin
              idle_cnt <= idle_cnt + 32'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queues feed the bus, a uart model
// acks every ready byte, and a scoreboard checks the uart byte stream in order.
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] grant_id;
  logic       busy;
  logic       abort_pulse;
  logic       trunc_pulse;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N(N)) bus ();

  uart_tx_arbiter #(
    .N(N), .HDR_EN(1), .HDR_BASE(8'hA0), .TIMEOUT(20), .MAX_BYTES(4)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .grant_id(grant_id), .busy(busy),
    .abort_pulse(abort_pulse), .trunc_pulse(trunc_pulse), .state_dbg(state_dbg)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Per-requester pending bytes: {last, data}.
  logic [8:0] src_q [N][$];
  logic [7:0] exp_q[$];

  int   cyc = 0;
  int   ack_cnt [N];
  int   abort_cnt, trunc_cnt, abort_cyc, trunc_cyc;
  int   last_acc_cyc, busy_fall_cyc, bad_ack;
  logic prev_busy = 1'b0;

  task automatic clear_stats();
    for (int i = 0; i < N; i++) ack_cnt[i] = 0;
    abort_cnt = 0; trunc_cnt = 0; abort_cyc = 0; trunc_cyc = 0;
    last_acc_cyc = 0; busy_fall_cyc = 0; bad_ack = 0;
  endtask

  // One clock: drive requesters after the edge, let the uart model ack, then sample.
  task automatic tick();
    logic [N-1:0] own;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        bus.req_valid[i]        = 1'b1;
        bus.req_data[8*i +: 8]  = src_q[i][0][7:0];
        bus.req_last[i]         = src_q[i][0][8];
      end else begin
        bus.req_valid[i] = 1'b0;
        bus.req_last[i]  = 1'b0;
      end
    end
    #1;
    bus.uart_tx_ack = bus.uart_tx_rdy;
    #1;
    cyc++;
    if (bus.uart_tx_rdy && bus.uart_tx_ack) begin
      last_acc_cyc = cyc;
      if (exp_q.size() > 0) check("uart_byte", 32'(bus.uart_tx_data), 32'(exp_q.pop_front()));
      else                  check("uart_extra", 32'(bus.uart_tx_data), 32'hFFFF_FFFF);
    end
    for (int i = 0; i < N; i++) begin
      if (bus.req_ack[i]) begin
        ack_cnt[i]++;
        if (src_q[i].size() > 0) void'(src_q[i].pop_front());
      end
    end
    own = '0;
    own[grant_id] = 1'b1;
    if ((bus.req_ack & ~own) != '0) bad_ack++;
    if (abort_pulse) begin
      if (abort_cnt == 0) abort_cyc = cyc;
      abort_cnt++;
    end
    if (trunc_pulse) begin
      if (trunc_cnt == 0) trunc_cyc = cyc;
      trunc_cnt++;
    end
    if (prev_busy && !busy && busy_fall_cyc == 0) busy_fall_cyc = cyc;
    prev_busy = busy;
  endtask

  function automatic int pending();
    int p = exp_q.size();
    for (int i = 0; i < N; i++) p += src_q[i].size();
    return p;
  endfunction

  task automatic do_reset();
    for (int i = 0; i < N; i++) src_q[i].delete();
    exp_q.delete();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    clear_stats();
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (n < budget && (pending() != 0 || busy)) begin
      tick();
      n++;
    end
    check({tag, "_drain_left"}, 32'(pending()), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.req_data    = '0;
    bus.req_valid   = '0;
    bus.req_last    = '0;
    bus.uart_tx_ack = 1'b0;
    clear_stats();

    // Reset state
    do_reset();
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_rdy",   32'(bus.uart_tx_rdy), 32'd0);
    check("rst_data",  32'(bus.uart_tx_data), 32'd0);
    check("rst_ack",   32'(bus.req_ack), 32'd0);
    check("rst_pulse", 32'({abort_pulse, trunc_pulse}), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);

    // Header and payload: requester 2 sends 0x11, 0x22(last)
    do_reset();
    src_q[2].push_back(9'h011);
    src_q[2].push_back(9'h122);
    exp_q = '{8'hA2, 8'h11, 8'h22};
    drain("hdr", 40);
    check("hdr_ack2", 32'(ack_cnt[2]), 32'd2);
    check("hdr_busy_fall", 32'(busy_fall_cyc - last_acc_cyc), 32'd1);
    check("hdr_busy", 32'(busy), 32'd0);

    // Round-robin among requesters 0, 1, 3 with one-byte packets
    do_reset();
    src_q[0] = '{9'h101, 9'h102};
    src_q[1] = '{9'h111, 9'h112};
    src_q[3] = '{9'h131, 9'h132};
    exp_q = '{8'hA0, 8'h01, 8'hA1, 8'h11, 8'hA3, 8'h31,
              8'hA0, 8'h02, 8'hA1, 8'h12, 8'hA3, 8'h32};
    drain("rr", 80);
    check("rr_ack0", 32'(ack_cnt[0]), 32'd2);
    check("rr_ack1", 32'(ack_cnt[1]), 32'd2);
    check("rr_ack3", 32'(ack_cnt[3]), 32'd2);
    check("rr_bad_ack", 32'(bad_ack), 32'd0);

    // Packet lock: requester 1 holds the link for 3 bytes while 0 waits
    do_reset();
    src_q[1] = '{9'h01A, 9'h01B, 9'h11C};
    tick();
    src_q[0] = '{9'h10A};
    exp_q = '{8'hA1, 8'h1A, 8'h1B, 8'h1C, 8'hA0, 8'h0A};
    drain("lock", 60);
    check("lock_ack0", 32'(ack_cnt[0]), 32'd1);
    check("lock_ack1", 32'(ack_cnt[1]), 32'd3);
    check("lock_bad_ack", 32'(bad_ack), 32'd0);

    // Timeout: requester 0 stalls after one byte; 2 takes over after the abort.
    // The 20th idle cycle triggers the abort; the pulse shows one cycle later.
    do_reset();
    src_q[0] = '{9'h055};
    src_q[2] = '{9'h166};
    exp_q = '{8'hA0, 8'h55, 8'hA2, 8'h66};
    for (int n = 0; n < 60 && abort_cnt == 0; n++) tick();
    check("to_delay", 32'(abort_cyc - last_acc_cyc), 32'd21);
    check("to_busy", 32'(busy), 32'd0);
    drain("to", 40);
    check("to_abort_cnt", 32'(abort_cnt), 32'd1);
    check("to_ack2", 32'(ack_cnt[2]), 32'd1);
    check("to_trunc_cnt", 32'(trunc_cnt), 32'd0);

    // Truncation: requester 3 offers 6 bytes without last; only 4 are taken
    do_reset();
    for (int b = 0; b < 6; b++) src_q[3].push_back({1'b0, 8'(8'h30 + b)});
    exp_q = '{8'hA3, 8'h30, 8'h31, 8'h32, 8'h33};
    for (int n = 0; n < 40 && ack_cnt[3] < 4; n++) tick();
    check("tr_left", 32'(src_q[3].size()), 32'd2);
    src_q[3].delete();
    for (int n = 0; n < 3; n++) tick();
    check("tr_cnt", 32'(trunc_cnt), 32'd1);
    check("tr_delay", 32'(trunc_cyc - last_acc_cyc), 32'd1);
    check("tr_ack3", 32'(ack_cnt[3]), 32'd4);
    check("tr_exp_left", 32'(exp_q.size()), 32'd0);
    check("tr_abort_cnt", 32'(abort_cnt), 32'd0);

    // Exactly MAX_BYTES with last on the final byte: normal end
    clear_stats();
    src_q[3] = '{9'h040, 9'h041, 9'h042, 9'h143};
    exp_q = '{8'hA3, 8'h40, 8'h41, 8'h42, 8'h43};
    drain("cap_last", 40);
    check("cap_last_trunc", 32'(trunc_cnt), 32'd0);
    check("cap_last_ack3", 32'(ack_cnt[3]), 32'd4);

    // Reset mid-packet, then first grant goes to requester 0
    do_reset();
    src_q[1] = '{9'h01A, 9'h01B, 9'h11C};
    exp_q = '{8'hA1, 8'h1A, 8'h1B, 8'h1C};
    for (int n = 0; n < 20 && ack_cnt[1] < 1; n++) tick();
    check("mid_state", 32'(state_dbg), 32'd2);
    exp_q.delete();
    src_q[1] = '{9'h11F};
    src_q[0] = '{9'h10F};
    rst = 1'b1;
    tick();
    check("mid_busy",  32'(busy), 32'd0);
    check("mid_rdy",   32'(bus.uart_tx_rdy), 32'd0);
    check("mid_grant", 32'(grant_id), 32'd0);
    check("mid_ack",   32'(bus.req_ack), 32'd0);
    check("mid_pulse", 32'({abort_pulse, trunc_pulse}), 32'd0);
    rst = 1'b0;
    clear_stats();
    exp_q = '{8'hA0, 8'h0F, 8'hA1, 8'h1F};
    drain("mid", 40);
    check("mid_ack0", 32'(ack_cnt[0]), 32'd1);
    check("mid_ack1", 32'(ack_cnt[1]), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
